// File: rtl/ascii_seq_gen.sv
// ASCII test-pattern sequencer: streams LEN characters from START_CHAR over valid/ready.
// Optional CR/LF message tail is compiled in with `define ASCII_SEQ_CRLF_EN.
module ascii_seq_gen #(
  parameter logic [7:0] START_CHAR = 8'h41,
  parameter int          LEN        = 16,
  parameter int          IDX_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             loop,
  input  logic             abort,
  input  logic             tx_ready,
  output logic             tx_valid,
  output logic [7:0]       tx_data,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] char_idx
);

`ifdef ASCII_SEQ_CRLF_EN
  typedef enum logic [1:0] {IDLE, SEND, CR, LF} state_t;
`else
  typedef enum logic [1:0] {IDLE, SEND} state_t;
`endif

  localparam logic [IDX_W-1:0] LAST = IDX_W'(LEN - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             xfer;

  // Handshake is judged against the registered valid, so no input reaches an output combinationally.
  assign xfer = valid_q & tx_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        idx_d = '0;
        if (start) state_d = SEND;
      end
      SEND: begin
        if (xfer) begin
          if (idx_q == LAST) begin
`ifdef ASCII_SEQ_CRLF_EN
            state_d = CR;
`else
            if (loop) begin
              idx_d = '0;
            end else begin
              state_d = IDLE;
              idx_d   = '0;
              done_d  = 1'b1;
            end
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
`ifdef ASCII_SEQ_CRLF_EN
      CR: begin
        if (xfer) state_d = LF;
      end
      LF: begin
        if (xfer) begin
          idx_d = '0;
          if (loop) begin
            state_d = SEND;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
`endif
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase

    // Abort wins over loop, start and completion; a coincident transfer still counts as sent.
    if (abort) begin
      state_d = IDLE;
      idx_d   = '0;
      done_d  = 1'b0;
    end

    valid_d = (state_d != IDLE);
    busy_d  = (state_d != IDLE);
    case (state_d)
      SEND:    data_d = START_CHAR + 8'(idx_d);
`ifdef ASCII_SEQ_CRLF_EN
      CR:      data_d = 8'h0D;
      LF:      data_d = 8'h0A;
`endif
      default: data_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx_valid = valid_q;
  assign tx_data  = data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign char_idx = idx_q;

endmodule

// File: tb/tb_ascii_seq_gen.sv
// Bench for ascii_seq_gen: four parameter variants share one input set; vectors, directed corners, random vs model.
module tb_ascii_seq_gen;

`ifdef ASCII_SEQ_CRLF_EN
  localparam int TAIL = 2;
`else
  localparam int TAIL = 0;
`endif

  localparam int NI = 4;
  int          LENS [NI] = '{16, 4, 3, 2};
  logic [7:0]  STS  [NI] = '{8'h41, 8'hFE, 8'h30, 8'h41};

  logic clk = 0, rst = 1;
  logic start = 0, loop = 0, abort = 0, rdy = 0;
  logic [NI-1:0] vld, bsy, dn;
  logic [7:0]    dat [NI];
  logic [7:0]    idx [NI];

  always #5 clk = ~clk;

  ascii_seq_gen #(.START_CHAR(8'h41), .LEN(16), .IDX_W(8)) u0 (
    .clk(clk), .rst(rst), .start(start), .loop(loop), .abort(abort), .tx_ready(rdy),
    .tx_valid(vld[0]), .tx_data(dat[0]), .busy(bsy[0]), .done(dn[0]), .char_idx(idx[0]));
  ascii_seq_gen #(.START_CHAR(8'hFE), .LEN(4), .IDX_W(8)) u1 (
    .clk(clk), .rst(rst), .start(start), .loop(loop), .abort(abort), .tx_ready(rdy),
    .tx_valid(vld[1]), .tx_data(dat[1]), .busy(bsy[1]), .done(dn[1]), .char_idx(idx[1]));
  ascii_seq_gen #(.START_CHAR(8'h30), .LEN(3), .IDX_W(8)) u2 (
    .clk(clk), .rst(rst), .start(start), .loop(loop), .abort(abort), .tx_ready(rdy),
    .tx_valid(vld[2]), .tx_data(dat[2]), .busy(bsy[2]), .done(dn[2]), .char_idx(idx[2]));
  ascii_seq_gen #(.START_CHAR(8'h41), .LEN(2), .IDX_W(8)) u3 (
    .clk(clk), .rst(rst), .start(start), .loop(loop), .abort(abort), .tx_ready(rdy),
    .tx_valid(vld[3]), .tx_data(dat[3]), .busy(bsy[3]), .done(dn[3]), .char_idx(idx[3]));

  int errors = 0, checks = 0;
  int mon_k = 0;
  logic [7:0] txq [$];

  always @(posedge clk)
    if (!rst && vld[mon_k] && rdy) txq.push_back(dat[mon_k]);

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  function automatic int ml(input int k);
    return LENS[k] + TAIL;
  endfunction

  // Message position p -> character, straight from the message definition.
  function automatic logic [7:0] msg_char(input int k, input int p);
    if (p < LENS[k]) return 8'((int'(STS[k]) + p) % 256);
    return (p == LENS[k]) ? 8'h0D : 8'h0A;
  endfunction

  task automatic do_reset();
    rst = 1; start = 0; loop = 0; abort = 0; rdy = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic run_msg(input int k, input bit tog, output int cyc);
    logic [7:0] pd;
    logic pv, pr;
    txq.delete(); mon_k = k; start = 1; pv = 0; pd = 0; cyc = -1;
    for (int c = 0; c < 200; c++) begin
      rdy = tog ? (c % 2 == 0) : 1'b1;
      pr = rdy;
      @(posedge clk); #1; start = 0;
      if (pv && !pr && vld[k]) chk("stall_hold_data", dat[k], pd);
      pv = vld[k]; pd = dat[k];
      if (dn[k]) begin cyc = c; break; end
    end
    if (cyc < 0) chk("msg_timeout", 0, 1);
  endtask

  task automatic check_msg(input int k, input string nm);
    chk({nm, "_count"}, txq.size(), ml(k));
    for (int i = 0; i < txq.size() && i < ml(k); i++) chk({nm, "_char"}, txq[i], msg_char(k, i));
    chk({nm, "_busy_at_done"}, bsy[k], 0);
    @(posedge clk); #1;
    chk({nm, "_done_one_cycle"}, dn[k], 0);
  endtask

  typedef struct {
    logic st, lp, ab, rd;
    logic ev; logic [7:0] ed; logic [7:0] ei; logic eb; logic edn;
  } vec_t;
  vec_t tbl [12];

  int m_act [NI], m_pos [NI];
  bit m_done [NI];

  initial begin
    int cyc;
    tbl[0]  = '{1,0,0,0, 1,8'h41,8'd0,1,0};
    tbl[1]  = '{0,0,0,0, 1,8'h41,8'd0,1,0};
    tbl[2]  = '{0,0,0,1, 1,8'h42,8'd1,1,0};
    tbl[3]  = '{1,0,0,1, 1,8'h43,8'd2,1,0};
    tbl[4]  = '{0,0,0,0, 1,8'h43,8'd2,1,0};
    tbl[5]  = '{0,0,0,1, 1,8'h44,8'd3,1,0};
    tbl[6]  = '{0,0,0,1, 1,8'h45,8'd4,1,0};
    tbl[7]  = '{0,0,1,1, 0,8'h00,8'd0,0,0};
    tbl[8]  = '{0,0,0,1, 0,8'h00,8'd0,0,0};
    tbl[9]  = '{1,0,0,0, 1,8'h41,8'd0,1,0};
    tbl[10] = '{0,0,1,0, 0,8'h00,8'd0,0,0};
    tbl[11] = '{1,1,1,1, 0,8'h00,8'd0,0,0};

    // Reset state
    do_reset();
    chk("rst_valid", vld[0], 0);
    chk("rst_data", dat[0], 8'h00);
    chk("rst_busy", bsy[0], 0);
    chk("rst_done", dn[0], 0);
    chk("rst_idx", idx[0], 0);

    // Vector table: stalls, ignored start, abort on the 5th transfer, abort over start
    txq.delete(); mon_k = 0;
    for (int i = 0; i < 12; i++) begin
      start = tbl[i].st; loop = tbl[i].lp; abort = tbl[i].ab; rdy = tbl[i].rd;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_valid", i), vld[0], tbl[i].ev);
      if (tbl[i].ev) chk($sformatf("vec%0d_data", i), dat[0], tbl[i].ed);
      chk($sformatf("vec%0d_idx", i), idx[0], tbl[i].ei);
      chk($sformatf("vec%0d_busy", i), bsy[0], tbl[i].eb);
      chk($sformatf("vec%0d_done", i), dn[0], tbl[i].edn);
    end
    chk("abort_xfer_count", txq.size(), 5);
    start = 0; loop = 0; abort = 0; rdy = 0;

    // Full message, ready high: no bubbles
    do_reset();
    run_msg(0, 0, cyc);
    chk("full_cycles", cyc, ml(0));
    check_msg(0, "full");

    // Ready toggling
    do_reset();
    run_msg(0, 1, cyc);
    check_msg(0, "toggle");

    // START_CHAR wrap
    do_reset();
    run_msg(1, 0, cyc);
    check_msg(1, "wrap");

    // Loop held, then dropped
    do_reset();
    txq.delete(); mon_k = 2; loop = 1; rdy = 1; start = 1;
    @(posedge clk); #1; start = 0;
    for (int i = 0; i < 2 * ml(2); i++) begin
      @(posedge clk); #1;
      chk("loop_valid", vld[2], 1);
      chk("loop_no_done", dn[2], 0);
    end
    loop = 0; cyc = -1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (dn[2]) begin cyc = c; break; end
    end
    if (cyc < 0) chk("loop_timeout", 0, 1);
    chk("loop_count", txq.size(), 3 * ml(2));
    for (int i = 0; i < txq.size() && i < 3 * ml(2); i++) chk("loop_char", txq[i], msg_char(2, i % ml(2)));

    // Asynchronous reset mid-message (during CR when the tail exists)
    do_reset();
    rdy = 1; start = 1;
    @(posedge clk); #1; start = 0;
    cyc = -1;
    for (int c = 0; c < 20; c++) begin
      if (vld[3] && dat[3] == ((TAIL != 0) ? 8'h0D : 8'h42)) begin cyc = c; break; end
      @(posedge clk); #1;
    end
    if (cyc < 0) chk("midrst_reach", 0, 1);
    #2 rst = 1;
    #1;
    chk("midrst_valid", vld[3], 0);
    chk("midrst_busy", bsy[3], 0);
    chk("midrst_idx", idx[3], 0);
    chk("midrst_data", dat[3], 8'h00);
    @(posedge clk); #1 rst = 0;
    @(posedge clk); #1;
    chk("midrst_waits", vld[3], 0);
    start = 1;
    @(posedge clk); #1; start = 0;
    chk("midrst_restart_valid", vld[3], 1);
    chk("midrst_restart_data", dat[3], 8'h41);
    chk("midrst_restart_idx", idx[3], 0);

    // Random stimulus against a message-position model
    do_reset();
    for (int k = 0; k < NI; k++) begin m_act[k] = 0; m_pos[k] = 0; m_done[k] = 0; end
    for (int n = 0; n < 3000; n++) begin
      start = ($urandom % 4 == 0);
      abort = ($urandom % 40 == 0);
      rdy   = ($urandom % 10 < 7);
      if ($urandom % 8 == 0) loop = ~loop;
      @(posedge clk); #1;
      for (int k = 0; k < NI; k++) begin
        m_done[k] = 0;
        if (abort) begin
          m_act[k] = 0; m_pos[k] = 0;
        end else if (m_act[k] != 0) begin
          if (rdy) begin
            if (m_pos[k] == ml(k) - 1) begin
              m_pos[k] = 0;
              if (!loop) begin m_act[k] = 0; m_done[k] = 1; end
            end else begin
              m_pos[k]++;
            end
          end
        end else if (start) begin
          m_act[k] = 1; m_pos[k] = 0;
        end
        chk($sformatf("rnd%0d_valid", k), vld[k], m_act[k]);
        chk($sformatf("rnd%0d_busy", k), bsy[k], m_act[k]);
        chk($sformatf("rnd%0d_done", k), dn[k], m_done[k]);
        chk($sformatf("rnd%0d_idx", k), idx[k],
            (m_act[k] == 0) ? 0 : ((m_pos[k] < LENS[k]) ? m_pos[k] : LENS[k] - 1));
        if (m_act[k] != 0) chk($sformatf("rnd%0d_data", k), dat[k], msg_char(k, m_pos[k]));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
